// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and default sizes for the multiply/divide unit
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - start/busy/done request and HI/LO result bundle; div0 present with MDU_DIV0_FLAG_EN
interface mdu_seq_if #(
  parameter int WIDTH = mdu_pkg::MDU_WIDTH
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
  logic             div0;
`endif

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, hi, lo
`ifdef MDU_DIV0_FLAG_EN
    , output div0
`endif
  );

  modport master (
    output start, op, a, b,
    input  ready, busy, done, hi, lo
`ifdef MDU_DIV0_FLAG_EN
    , input div0
`endif
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - operand magnitude extraction and signed result correction
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_mag_a,
  output logic [WIDTH-1:0] o_mag_b,
  output logic             o_sa,
  output logic             o_sb,
  input  logic             i_is_div,
  input  logic             i_neg_main,
  input  logic             i_neg_rem,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign o_sa    = i_a[WIDTH-1];
  assign o_sb    = i_b[WIDTH-1];
  assign o_mag_a = (i_signed && o_sa) ? (~i_a + 1'b1) : i_a;
  assign o_mag_b = (i_signed && o_sb) ? (~i_b + 1'b1) : i_b;

  assign w_prod     = {i_hi, i_lo};
  assign w_prod_neg = ~w_prod + 1'b1;

  // Product is negated as one 64-bit value; quotient and remainder are corrected independently.
  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (!i_is_div) begin
      if (i_neg_main) begin
        o_hi = w_prod_neg[2*WIDTH-1:WIDTH];
        o_lo = w_prod_neg[WIDTH-1:0];
      end
    end else begin
      if (i_neg_main) o_lo = ~i_lo + 1'b1;
      if (i_neg_rem)  o_hi = ~i_hi + 1'b1;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - radix-2 iterative MULT/MULTU/DIV/DIVU into HI/LO; MDU_DIV0_FLAG_EN adds fast divide-by-zero with div0 flag
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input logic       clk,
  input logic       rst,
  mdu_seq_if.slave  bus
);

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_x;      // multiplicand (mul) or divisor (div), magnitude
  logic [WIDTH-1:0] r_rem;    // product high half (mul) or remainder (div)
  logic [WIDTH-1:0] r_q;      // multiplier/product low half (mul) or dividend/quotient (div)
  logic             r_sa;
  logic             r_sb;
  logic             r_fin;    // all WIDTH steps done; next CALC edge commits HI/LO
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
`ifdef MDU_DIV0_FLAG_EN
  logic             r_div0;
`endif

  op_e              w_in_op;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_sa;
  logic             w_sb;
  logic             w_div0_run;
  logic             w_neg_main;
  logic             w_neg_rem;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_q_n;

  assign w_in_op = op_e'(bus.op);

  // A zero divisor leaves the quotient at all ones unsigned. The remainder fix stays on
  // so a negative dividend's magnitude is turned back into the original HI value.
  assign w_div0_run = op_is_div(r_op) && (r_x == '0);
  assign w_neg_main = op_is_signed(r_op) && (r_sa ^ r_sb) && !w_div0_run;
  assign w_neg_rem  = op_is_div(r_op) && op_is_signed(r_op) && r_sa;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_a        (bus.a),
    .i_b        (bus.b),
    .i_signed   (op_is_signed(w_in_op)),
    .o_mag_a    (w_mag_a),
    .o_mag_b    (w_mag_b),
    .o_sa       (w_sa),
    .o_sb       (w_sb),
    .i_is_div   (op_is_div(r_op)),
    .i_neg_main (w_neg_main),
    .i_neg_rem  (w_neg_rem),
    .i_hi       (r_rem),
    .i_lo       (r_q),
    .o_hi       (w_fix_hi),
    .o_lo       (w_fix_lo)
  );

  // One iteration: shift-add for multiply, restoring subtract on a 33-bit partial remainder for divide.
  always_comb begin
    w_mul_sum = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_x} : '0);
    w_shift   = {r_rem, r_q[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_x});
    w_diff    = w_shift[WIDTH-1:0] - r_x;
    w_rem_n   = r_rem;
    w_q_n     = r_q;
    if (!op_is_div(r_op)) begin
      w_rem_n = w_mul_sum[WIDTH:1];
      w_q_n   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end else if (w_ge) begin
      w_rem_n = w_diff;
      w_q_n   = {r_q[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_n = w_shift[WIDTH-1:0];
      w_q_n   = {r_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered handshake outputs, operand capture and HI/LO commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MULTU;
      r_x     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_fin   <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MDU_DIV0_FLAG_EN
      r_div0  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
          r_div0 <= 1'b0;
`endif
          if (bus.start) begin
            r_op  <= w_in_op;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_cnt <= '0;
            r_fin <= 1'b0;
            r_rem <= '0;
            r_q   <= op_is_div(w_in_op) ? w_mag_a : w_mag_b;
            r_x   <= op_is_div(w_in_op) ? w_mag_b : w_mag_a;
`ifdef MDU_DIV0_FLAG_EN
            if (op_is_div(w_in_op) && (bus.b == '0)) begin
              r_state <= ST_DONE;
              r_hi    <= bus.a;
              r_lo    <= '1;
              r_done  <= 1'b1;
              r_div0  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_CALC;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
`else
            r_state <= ST_CALC;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
`endif
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_CALC: begin
          if (r_fin) begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_rem <= w_rem_n;
            r_q   <= w_q_n;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) r_fin <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
`ifdef MDU_DIV0_FLAG_EN
  assign bus.div0  = r_div0;
`endif

endmodule
